idc_host: RTL

IDC_HOST -- requirements
Module: idc_host

---
 rtl/idc_host.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/idc_host.sv
// Host-side sequencer for an image-domain compute (IDC) block: streams a stored
// 8x8 image plus operation list to the IDC, then collects a 16-entry result burst.
module idc_host #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_valid,
    input  logic [5:0] ld_addr,
    input  logic [6:0] ld_data,
    input  logic       op_we,
    input  logic [3:0] op_addr,
    input  logic [3:0] op_wdata,
    input  logic       start,
    output logic       in_valid,
    output logic [6:0] in_data,
    output logic [3:0] op,
    input  logic       out_valid,
    input  logic [6:0] out_data,
    input  logic [3:0] rd_addr,
    output logic [6:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FIN} state_t;

    state_t        state_reg, state_next;
    logic [5:0]    beat_reg, beat_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [3:0]    recv_reg, recv_next;
    logic          err_reg, err_next;
    logic          cap_en;
    logic [3:0]    cap_idx;
    logic          in_valid_reg, in_valid_next;
    logic [6:0]    in_data_reg, in_data_next;
    logic [3:0]    op_reg, op_next;

    logic [6:0] image_mem  [64];
    logic [3:0] op_mem     [15];
    logic [6:0] result_mem [16];

    // Host writes are only accepted while no transaction is in flight.
    logic host_we;
    assign host_we = (state_reg == IDLE) || (state_reg == FIN);

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_image
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    image_mem[gi] <= '0;
                else if (host_we && ld_valid && ld_addr == 6'(gi))
                    image_mem[gi] <= ld_data;
            end
        end
        for (gi = 0; gi < 15; gi++) begin : g_op
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    op_mem[gi] <= '0;
                else if (host_we && op_we && op_addr == 4'(gi))
                    op_mem[gi] <= op_wdata;
            end
        end
        for (gi = 0; gi < 16; gi++) begin : g_result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    result_mem[gi] <= '0;
                else if (cap_en && cap_idx == 4'(gi))
                    result_mem[gi] <= out_data;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            wait_reg     <= '0;
            recv_reg     <= '0;
            err_reg      <= 1'b0;
            in_valid_reg <= 1'b0;
            in_data_reg  <= '0;
            op_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            wait_reg     <= wait_next;
            recv_reg     <= recv_next;
            err_reg      <= err_next;
            in_valid_reg <= in_valid_next;
            in_data_reg  <= in_data_next;
            op_reg       <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        wait_next  = wait_reg;
        recv_next  = recv_reg;
        err_next   = 1'b0;
        cap_en     = 1'b0;
        cap_idx    = recv_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                    beat_next  = '0;
                end
            end
            SEND: begin
                if (beat_reg == 6'd63) begin
                    state_next = WAIT;
                    wait_next  = '0;
                end else begin
                    beat_next = beat_reg + 6'd1;
                end
            end
            WAIT: begin
                if (out_valid) begin
                    state_next = RECV;
                    recv_next  = 4'd1;
                    cap_en     = 1'b1;
                    cap_idx    = 4'd0;
                end else if (wait_reg == CW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    wait_next = wait_reg + CW'(1);
                end
            end
            RECV: begin
                if (out_valid) begin
                    cap_en = 1'b1;
                    if (recv_reg == 4'd15)
                        state_next = FIN;
                    else
                        recv_next = recv_reg + 4'd1;
                end else begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stream outputs are precomputed from the next beat so they appear registered.
    always_comb begin
        in_valid_next = 1'b0;
        in_data_next  = '0;
        op_next       = '0;
        if (state_next == SEND) begin
            in_valid_next = 1'b1;
            in_data_next  = image_mem[beat_next];
            if (beat_next < 6'd15)
                op_next = op_mem[beat_next[3:0]];
        end
    end

    assign in_valid = in_valid_reg;
    assign in_data  = in_data_reg;
    assign op       = op_reg;
    assign busy     = (state_reg == SEND) || (state_reg == WAIT) || (state_reg == RECV);
    assign done     = (state_reg == FIN);
    assign err      = err_reg;
    assign rd_data  = result_mem[rd_addr];
endmodule
